// File: rtl/cpu_run_pkg.sv
// Shared types and constants for the MIPS run controller.
package cpu_run_pkg;

    typedef enum logic [2:0] {
        st_idle,
        st_reset,
        st_run,
        st_done,
        st_timeout
    } state_t;

    localparam logic [31:0] OP_SYSCALL = 32'h0000000C;
    localparam int          CNT_W_DEF  = 32;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr has priority over inc.
module sat_counter
    import cpu_run_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the single-cycle MIPS core: reset pulse, clock enable,
// cycle/instruction counting and end-of-program detection.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int          RST_CYCLES  = 2,
    parameter int          MAX_CYCLES  = 1000,
    parameter int          CNT_W       = CNT_W_DEF,
    parameter logic [31:0] HALT_INSTR  = OP_SYSCALL,
    parameter int          LOOP_DET    = 1,
    parameter int          LOOP_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      pc,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    output logic             cpu_rst,
    output logic             cpu_en,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int RW = $clog2(RST_CYCLES) + 1;
    localparam int BW = $clog2(MAX_CYCLES) + 1;
    localparam int LW = $clog2(LOOP_CYCLES) + 1;

    state_t        state, state_n;
    logic [RW-1:0] rcnt;
    logic [BW-1:0] bcnt;
    logic [LW-1:0] lcnt;
    logic [31:0]   prev_pc;
    logic          prev_vld;

    logic in_run, retire, same_pc, halt_hit, loop_hit, budget_hit, enter_reset;

    assign in_run     = (state == st_run);
    assign retire     = in_run && instr_valid;
    assign same_pc    = prev_vld && (pc == prev_pc);
    assign halt_hit   = retire && (instr == HALT_INSTR);
    assign loop_hit   = (LOOP_DET != 0) && retire && same_pc && (lcnt == LW'(LOOP_CYCLES - 2));
    // Separate budget counter so a narrow CNT_W cannot hide the timeout.
    assign budget_hit = in_run && (bcnt == BW'(MAX_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= st_idle;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        enter_reset = 1'b0;
        case (state)
            st_idle: begin
                if (start) begin
                    state_n     = st_reset;
                    enter_reset = 1'b1;
                end
            end
            st_reset: begin
                if (rcnt == RW'(RST_CYCLES - 1)) begin
                    state_n = st_run;
                end
            end
            st_run: begin
                if (abort) begin
                    state_n = st_idle;
                end else if (halt_hit || loop_hit) begin
                    state_n = st_done;
                end else if (budget_hit) begin
                    state_n = st_timeout;
                end
            end
            st_done, st_timeout: begin
                if (start) begin
                    state_n     = st_reset;
                    enter_reset = 1'b1;
                end
            end
            default: state_n = st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt     <= '0;
            prev_vld <= 1'b0;
        end else begin
            if (enter_reset) begin
                rcnt <= '0;
            end else if (state == st_reset) begin
                rcnt <= rcnt + RW'(1);
            end
            if (enter_reset) begin
                prev_vld <= 1'b0;
            end else if (retire) begin
                prev_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (retire) begin
            prev_pc <= pc;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle (
        .clk (clk),
        .rst (rst),
        .clr (enter_reset),
        .inc (in_run),
        .q   (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_instr (
        .clk (clk),
        .rst (rst),
        .clr (enter_reset),
        .inc (retire),
        .q   (instr_cnt)
    );

    sat_counter #(.W(LW)) u_loop (
        .clk (clk),
        .rst (rst),
        .clr (enter_reset || (retire && !same_pc)),
        .inc (retire && same_pc),
        .q   (lcnt)
    );

    sat_counter #(.W(BW)) u_budget (
        .clk (clk),
        .rst (rst),
        .clr (enter_reset),
        .inc (in_run),
        .q   (bcnt)
    );

    assign cpu_rst = (state == st_idle) || (state == st_reset);
    assign cpu_en  = (state == st_reset) || (state == st_run);
    assign running = (state == st_run);
    assign done    = (state == st_done);
    assign timeout = (state == st_timeout);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench: three controller configurations share one stimulus stream.
module tb_cpu_run_ctrl;

    localparam int          L     = 45;
    localparam int          LOOPC = 4;
    localparam logic [31:0] HALT  = 32'h0000000C;

    typedef struct {
        logic dn;
        logic to;
        logic idle;
        int   cyc;
        int   ins;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;

    logic        cr[3], ce[3], rn[3], dn[3], to[3];
    logic [31:0] cc[3], ic[3];
    logic [3:0]  cc2, ic2;

    logic        sv[L];
    logic        sab[L];
    logic [31:0] spc[L], sins[L];

    exp_t q0[$], q1[$], q2[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b1;
    logic prev_run[3] = '{1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    cpu_run_ctrl #(.MAX_CYCLES(20), .CNT_W(32), .LOOP_DET(1)) dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pc(pc), .instr(instr),
        .instr_valid(instr_valid), .cpu_rst(cr[0]), .cpu_en(ce[0]), .running(rn[0]),
        .done(dn[0]), .timeout(to[0]), .cycle_cnt(cc[0]), .instr_cnt(ic[0])
    );

    cpu_run_ctrl #(.MAX_CYCLES(20), .CNT_W(32), .LOOP_DET(0)) dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pc(pc), .instr(instr),
        .instr_valid(instr_valid), .cpu_rst(cr[1]), .cpu_en(ce[1]), .running(rn[1]),
        .done(dn[1]), .timeout(to[1]), .cycle_cnt(cc[1]), .instr_cnt(ic[1])
    );

    cpu_run_ctrl #(.MAX_CYCLES(40), .CNT_W(4), .LOOP_DET(1)) dut2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pc(pc), .instr(instr),
        .instr_valid(instr_valid), .cpu_rst(cr[2]), .cpu_en(ce[2]), .running(rn[2]),
        .done(dn[2]), .timeout(to[2]), .cycle_cnt(cc2), .instr_cnt(ic2)
    );

    assign cc[2] = {28'd0, cc2};
    assign ic[2] = {28'd0, ic2};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: walk the RUN cycles of the program and stop at the first end condition.
    function automatic int model(input int maxc, input int cntw, input bit ld, output exp_t e);
        int          ins = 0;
        int          streak = 0;
        bit          have = 0;
        logic [31:0] last = '0;
        longint      lim = (64'd1 << cntw) - 1;
        e = '{dn: 1'b0, to: 1'b1, idle: 1'b0, cyc: 0, ins: 0};
        for (int k = 0; k < L; k++) begin
            if (sv[k]) begin
                ins++;
                streak = (have && spc[k] == last) ? streak + 1 : 1;
                last = spc[k];
                have = 1;
            end
            e.cyc = (longint'(k + 1) > lim) ? int'(lim) : k + 1;
            e.ins = (longint'(ins) > lim) ? int'(lim) : ins;
            if (sab[k]) begin
                e.dn = 0; e.to = 0; e.idle = 1;
                return k + 1;
            end
            if (sv[k] && (sins[k] == HALT || (ld && streak >= LOOPC))) begin
                e.dn = 1; e.to = 0;
                return k + 1;
            end
            if (k + 1 == maxc) begin
                e.dn = 0; e.to = 1;
                return k + 1;
            end
        end
        return L;
    endfunction

    function automatic bit pop(input int d, output exp_t e);
        e = '{dn: 1'b0, to: 1'b0, idle: 1'b0, cyc: 0, ins: 0};
        case (d)
            0: if (q0.size() > 0) begin e = q0.pop_front(); return 1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); return 1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); return 1; end
        endcase
        return 0;
    endfunction

    // Monitor: a fall of running marks the end of a run; compare against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (mon_en && prev_run[d] && !rn[d]) begin
                    if (!pop(d, e)) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL d%0d unexpected end: cycle_cnt %0d, no expectation queued", d, cc[d]);
                    end else begin
                        chk($sformatf("d%0d done", d), 32'(dn[d]), 32'(e.dn));
                        chk($sformatf("d%0d timeout", d), 32'(to[d]), 32'(e.to));
                        chk($sformatf("d%0d cycle_cnt", d), cc[d], 32'(e.cyc));
                        chk($sformatf("d%0d instr_cnt", d), ic[d], 32'(e.ins));
                        chk($sformatf("d%0d cpu_en", d), 32'(ce[d]), 32'd0);
                        chk($sformatf("d%0d cpu_rst", d), 32'(cr[d]), 32'(e.idle));
                    end
                end
                prev_run[d] = rn[d];
            end
        end
    end

    task automatic build(input int kind);
        for (int k = 0; k < L; k++) begin
            sv[k]   = 1'b1;
            sab[k]  = 1'b0;
            spc[k]  = 32'h0000_0400 + 32'(4 * k);
            sins[k] = 32'h8C00_0000 + 32'(k);
        end
        case (kind)
            0: begin
                sins[10] = HALT;
                for (int k = 11; k < L; k++) sv[k] = 1'b0;
            end
            2: for (int k = 0; k < L; k++) begin
                spc[k]  = 32'h0000_3010;
                sins[k] = 32'h1000_FFFF;
            end
            3: sins[19] = HALT;
            4: begin
                sins[5] = HALT;
                sab[5]  = 1'b1;
            end
            5: for (int k = 0; k < L; k++) begin
                sv[k]   = ($urandom_range(3) != 0);
                spc[k]  = (k > 0 && $urandom_range(2) == 0) ? spc[k-1] : 32'(k * 4);
                sins[k] = ($urandom_range(24) == 0) ? HALT : ($urandom() | 32'h0100_0000);
                sab[k]  = ($urandom_range(49) == 0);
            end
            default: ;
        endcase
    endtask

    task automatic run_prog(input int kind);
        exp_t e;
        int   n;
        int   nmax = 0;
        build(kind);
        n = model(20, 32, 1'b1, e); q0.push_back(e); if (n > nmax) nmax = n;
        n = model(20, 32, 1'b0, e); q1.push_back(e); if (n > nmax) nmax = n;
        n = model(40, 4, 1'b1, e);  q2.push_back(e); if (n > nmax) nmax = n;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("reset entry cpu_rst", 32'(cr[0]), 32'd1);
        chk("reset entry cpu_en", 32'(ce[0]), 32'd1);
        chk("reset entry flags", {30'd0, dn[0], to[0]}, 32'd0);
        chk("reset entry cycle_cnt", cc[0], 32'd0);
        chk("reset entry instr_cnt", ic[2], 32'd0);
        @(posedge clk); #1;
        chk("reset 2nd cpu_rst", 32'(cr[0]), 32'd1);
        chk("reset 2nd running", 32'(rn[0]), 32'd0);
        @(posedge clk); #1;
        chk("run entry cpu_rst", 32'(cr[0]), 32'd0);
        chk("run entry running", 32'(rn[1]), 32'd1);
        for (int k = 0; k < nmax; k++) begin
            instr_valid = sv[k];
            pc          = spc[k];
            instr       = sins[k];
            abort       = sab[k];
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        abort       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk($sformatf("kind%0d d0 pending", kind), 32'(q0.size()), 32'd0);
        chk($sformatf("kind%0d d1 pending", kind), 32'(q1.size()), 32'd0);
        chk($sformatf("kind%0d d2 pending", kind), 32'(q2.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst cpu_rst", 32'(cr[0]), 32'd1);
        chk("rst cpu_en", 32'(ce[0]), 32'd0);
        chk("rst running", 32'(rn[0]), 32'd0);
        chk("rst flags", {30'd0, dn[2], to[2]}, 32'd0);
        chk("rst cycle_cnt", cc[0], 32'd0);
        chk("rst instr_cnt", ic[0], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int kind = 0; kind < 5; kind++) run_prog(kind);
        for (int r = 0; r < 8; r++) run_prog(5);

        // Reset in the middle of a run returns straight to the idle values.
        build(1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            instr_valid = sv[k];
            pc          = spc[k];
            instr       = sins[k];
            @(posedge clk); #1;
        end
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrun rst cpu_rst", 32'(cr[0]), 32'd1);
        chk("midrun rst cpu_en", 32'(ce[0]), 32'd0);
        chk("midrun rst running", 32'(rn[0]), 32'd0);
        chk("midrun rst flags", {30'd0, dn[0], to[0]}, 32'd0);
        chk("midrun rst cycle_cnt", cc[0], 32'd0);
        chk("midrun rst instr_cnt", ic[1], 32'd0);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        @(posedge clk); #1;
        run_prog(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
